matmul_drain: RTL
=================

# matmul_drain

Downstream stage of the matrix multiplier: once a product is complete in the Z result BRAM, this block reads the N×N result out through the BRAM read port and streams it as a valid/ready beat sequence. It supports row-major or column-major (transposed) readout. A 2-entry output buffer absorbs the 1-cycle BRAM read latency, so throughput is one element per clock under continuous ready with no loss under arbitrary backpressure.

## Interface
- DATA_WIDTH, 32, element width; matches Z BRAM data width
- ADDR_WIDTH, 6, Z BRAM address width; N*N <= 2**ADDR_WIDTH required
- N, 8, matrix dimension; Z element (r,c) lives at address r*N + c

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- start  in  1  begin readout; sampled only in IDLE
- col_major  in  1  sampled with start; 1 = transposed (column-major) order
- busy  out  1  high while a readout is in progress
- done  out  1  one-cycle pulse after the final beat handshakes
- z_rd_addr  out  ADDR_WIDTH  Z BRAM read address
- z_dout  in  DATA_WIDTH  Z BRAM read data; valid the cycle after the address is presented at a rising edge
- m_tdata  out  DATA_WIDTH  output element
- m_tvalid  out  1  m_tdata valid
- m_tready  in  1  consumer accepts; beat transfers on edge with tvalid & tready
- m_tlast  out  1  high on the final element (index N*N-1 of the sequence)
- m_row_last  out  1  high on every N-th element (end of row, or of column in col_major)

## Operation
- States: IDLE, RUN (issuing reads), FLUSH (all N*N reads issued, buffer draining), then back to IDLE with done pulse.
- IDLE: start=1 at an edge → RUN; latch col_major; clear element counters r=0, c=0. start while busy is ignored.
- Sequence index k = 0..N*N-1. Row-major: address k. Col-major: address (k mod N)*N + k/N. Implement with separate row/col counters, not a divider.
- Read issue rule: issue a read in a cycle iff RUN and (buffer_count + inflight - pop_now) < 2, where inflight = read issued in previous cycle, pop_now = tvalid & tready this cycle. z_rd_addr advances only on issue and holds otherwise.
- Read data is pushed into the 2-entry FIFO one cycle after issue; FIFO head drives m_tdata/m_tvalid/m_tlast/m_row_last. Flags travel with data.
- After issuing index N*N-1 → FLUSH. When FIFO is empty and no read is inflight after the last handshake → IDLE, done=1 for one cycle.
- Buffer never overflows; no beat is dropped or duplicated under any tready pattern.
- Reset mid-operation: state IDLE, FIFO emptied, counters cleared; the partial stream is abandoned; the next start restarts from k=0.

## Timing
- Reset values: busy 0, done 0, z_rd_addr 0, m_tvalid 0, m_tdata 0, m_tlast 0, m_row_last 0.
- start sampled at edge E0: busy high after E0; first address (0) presented after E0; first m_tvalid high after E2.
- With m_tready held 1: beats handshake on E3..E(N*N+2); done high in the cycle after E(N*N+2), with busy low in that same cycle. For N=8: last beat at E66, done after E66.
- start accepted in the done cycle (back-to-back readouts).
- m_tdata and flags stable while m_tvalid=1 and m_tready=0.
- z_rd_addr returns to 0 when entering IDLE.

## Test plan
- Z preloaded with value = address, N=8, row-major, tready=1 → 64 beats 0..63 on consecutive cycles, m_row_last on 7,15,…,63, m_tlast only on 63, done one cycle after beat 63.
- Same data, col_major=1 → beats 0,8,16,…,56,1,9,…,63; m_row_last on every 8th beat; m_tlast on 63.
- Random tready (50%) and a 20-cycle tready=0 stall → exact 64-value sequence with no loss or duplicate; m_tdata held stable during stalls; z_rd_addr stalls with at most 2 elements buffered.
- start pulsed again mid-readout → ignored; sequence unchanged; single done pulse.
- reset low at beat 30 → all outputs at reset values immediately; new start → full sequence from value 0.
- start asserted in the done cycle → second readout begins without a gap beyond the 2-cycle read latency.

Source files
------------

// File: rtl/matmul_drain.sv
// Streams an N x N result out of the Z BRAM as valid/ready beats, row- or column-major.
// A 2-entry buffer hides the one-cycle BRAM read latency so ready-held-high gives one beat per clock.
module matmul_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int N          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  col_major,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_row_last
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state;
    state_t                state_next;
    logic                  col_sel;
    logic [CW-1:0]         inner;
    logic [CW-1:0]         outer;
    logic                  inner_end;
    logic                  seq_end;
    logic                  issue;
    logic                  pop;
    logic                  done_next;
    logic [2:0]            occupancy;
    logic                  inflight;
    logic                  inflight_last;
    logic                  inflight_row_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic [1:0]            fifo_row_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    // inner walks fastest: columns in row-major order, rows in column-major order
    assign inner_end = (inner == CW'(N - 1));
    assign seq_end   = inner_end && (outer == CW'(N - 1));
    assign z_rd_addr = col_sel ? (ADDR_WIDTH'(inner) * ADDR_WIDTH'(N) + ADDR_WIDTH'(outer))
                               : (ADDR_WIDTH'(outer) * ADDR_WIDTH'(N) + ADDR_WIDTH'(inner));

    assign m_tvalid   = (count != 2'd0);
    assign pop        = m_tvalid && m_tready;
    assign m_tdata    = fifo_data[rd_ptr];
    assign m_tlast    = m_tvalid && fifo_last[rd_ptr];
    assign m_row_last = m_tvalid && fifo_row_last[rd_ptr];
    assign busy       = (state != IDLE);

    // Slots committed next cycle: buffered plus the read in flight, minus the beat leaving now
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (seq_end) state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (occupancy == 3'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last issued index is held until the drain completes, then counters return to zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_sel <= 1'b0;
            inner   <= '0;
            outer   <= '0;
        end else if (state == IDLE && start) begin
            col_sel <= col_major;
            inner   <= '0;
            outer   <= '0;
        end else if (issue && !seq_end) begin
            if (inner_end) begin
                inner <= '0;
                outer <= outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end else if (state == FLUSH && state_next == IDLE) begin
            inner <= '0;
            outer <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight          <= 1'b0;
            inflight_last     <= 1'b0;
            inflight_row_last <= 1'b0;
        end else begin
            inflight          <= issue;
            inflight_last     <= issue && seq_end;
            inflight_row_last <= issue && inner_end;
        end
    end

    // Flags ride alongside the data word so the head entry always describes itself
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= '0;
            fifo_row_last <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr]     <= z_dout;
                fifo_last[wr_ptr]     <= inflight_last;
                fifo_row_last[wr_ptr] <= inflight_row_last;
                wr_ptr                <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
